tlb_8b_ctrl: RTL and testbench

//  Small fully-associative TLB that translates 6-bit virtual page numbers (VPN) to 6-bit physical

---
 rtl/tlb_8b_ctrl.sv | 144 ++++++++++++++
 tb/tb_tlb_8b_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_8b_ctrl.sv
// Small fully-associative VPN->PPN translation cache with a page-table miss handshake.
// Misses fill the lowest free entry, otherwise the round-robin replacement slot.
module tlb_8b_ctrl #(
  parameter int unsigned TLB_ENTRIES    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  input  logic [5:0]  req_vpn_i,
  output logic        req_ready_o,
  output logic        resp_valid_o,
  output logic [5:0]  resp_ppn_o,
  output logic        resp_hit_o,
  output logic        resp_fault_o,
  input  logic        flush_i,
  output logic        pt_rqst_o,
  output logic [5:0]  pt_addr_o,
  input  logic        pt_complete_i,
  input  logic [11:0] pt_return_i
);

  localparam int unsigned PtrW = $clog2(TLB_ENTRIES);
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(TLB_ENTRIES - 1);

  typedef enum logic [2:0] {
    StIdle, StLookup, StMiss, StFill, StResp, StFault, StCool
  } state_e;

  state_e                 state_q, state_d;
  logic [TLB_ENTRIES-1:0] valid_q, valid_d;
  logic [5:0]             tag_q  [TLB_ENTRIES];
  logic [5:0]             data_q [TLB_ENTRIES];
  logic [PtrW-1:0]        ptr_q, ptr_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [5:0]             vpn_q, ppn_q, pt_addr_q;
  logic                   hit_q;

  logic                   lookup_hit;
  logic [5:0]             lookup_ppn;
  logic                   free_found;
  logic [PtrW-1:0]        free_idx, fill_idx;
  logic                   lookup_served;

  // The VPN half of the PTE is trusted rather than checked.
  logic unused_pte_vpn;
  assign unused_pte_vpn = ^pt_return_i[11:6];

  always_comb begin
    lookup_hit = 1'b0;
    lookup_ppn = '0;
    for (int i = 0; i < int'(TLB_ENTRIES); i++) begin
      if (valid_q[i] && tag_q[i] == vpn_q) begin
        lookup_hit = 1'b1;
        lookup_ppn = data_q[i];
      end
    end
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = int'(TLB_ENTRIES) - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = PtrW'(i);
      end
    end
  end

  assign fill_idx      = free_found ? free_idx : ptr_q;
  // A flush landing on the lookup edge must not be answered from stale entries.
  assign lookup_served = lookup_hit && !flush_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle:   if (req_valid_i) state_d = StLookup;
      StLookup: state_d = lookup_served ? StResp : StMiss;
      StMiss: begin
        if (pt_complete_i) begin
          state_d = StFill;
        end else if (cnt_q == CntLast) begin
          state_d = StFault;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StFill: begin
        state_d           = StResp;
        valid_d[fill_idx] = 1'b1;
        if (!free_found) ptr_d = (ptr_q == PtrLast) ? '0 : ptr_q + 1'b1;
      end
      StResp, StFault: state_d = StCool;
      StCool:          state_d = StIdle;
      default:         state_d = StIdle;
    endcase
    if (flush_i) valid_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      valid_q   <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      vpn_q     <= '0;
      ppn_q     <= '0;
      hit_q     <= 1'b0;
      pt_addr_q <= '0;
      for (int i = 0; i < int'(TLB_ENTRIES); i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      if (state_q == StIdle && req_valid_i) vpn_q <= req_vpn_i;
      if (state_q == StLookup) begin
        hit_q <= lookup_served;
        ppn_q <= lookup_ppn;
        if (!lookup_served) pt_addr_q <= vpn_q;
      end
      if (state_q == StMiss && pt_complete_i) ppn_q <= pt_return_i[5:0];
      if (state_q == StFill) begin
        tag_q[fill_idx]  <= vpn_q;
        data_q[fill_idx] <= ppn_q;
      end
    end
  end

  assign req_ready_o  = (state_q == StIdle);
  assign resp_valid_o = (state_q == StResp) || (state_q == StFault);
  assign resp_ppn_o   = (state_q == StResp) ? ppn_q : 6'h00;
  assign resp_hit_o   = (state_q == StResp) && hit_q;
  assign resp_fault_o = (state_q == StFault);
  assign pt_rqst_o    = (state_q == StMiss);
  assign pt_addr_o    = pt_addr_q;

endmodule

// File: tb/tb_tlb_8b_ctrl.sv
// Bench for tlb_8b_ctrl: a page-table responder model plus a response scoreboard
// holding {fault, hit, ppn} pushed at each request.
module tb_tlb_8b_ctrl;

  localparam int Entries = 4;
  localparam int Timeout = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [5:0]  req_vpn;
  logic        resp_valid, resp_hit, resp_fault;
  logic [5:0]  resp_ppn;
  logic        flush;
  logic        pt_rqst, pt_complete;
  logic [5:0]  pt_addr;
  logic [11:0] pt_return;

  int          n_vec = 0;
  int          n_err = 0;
  int          n_resp = 0;
  int          cyc = 0;
  int          last_resp_cyc = 0;
  int          pt_cmp_cyc = 0;
  bit          pt_en = 1'b1;
  int          pt_delay = 3;
  logic [7:0]  sb [$];

  tlb_8b_ctrl #(
    .TLB_ENTRIES    (Entries),
    .TIMEOUT_CYCLES (Timeout)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid_i   (req_valid),
    .req_vpn_i     (req_vpn),
    .req_ready_o   (req_ready),
    .resp_valid_o  (resp_valid),
    .resp_ppn_o    (resp_ppn),
    .resp_hit_o    (resp_hit),
    .resp_fault_o  (resp_fault),
    .flush_i       (flush),
    .pt_rqst_o     (pt_rqst),
    .pt_addr_o     (pt_addr),
    .pt_complete_i (pt_complete),
    .pt_return_i   (pt_return)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Page-table contents: vpn 0x05 maps to PTE 0x145, others to vpn ^ 0x15.
  function automatic logic [5:0] ppn_of(input logic [5:0] v);
    return (v == 6'h05) ? 6'h05 : (v ^ 6'h15);
  endfunction

  initial begin
    int wait_cnt;
    wait_cnt    = 0;
    pt_complete = 1'b0;
    pt_return   = 'z;
    forever begin
      @(negedge clk);
      if (pt_rqst && pt_en) begin
        wait_cnt++;
        if (wait_cnt >= pt_delay) begin
          pt_complete = 1'b1;
          pt_return   = {pt_addr, ppn_of(pt_addr)};
          pt_cmp_cyc  = cyc;
          @(negedge clk);
          pt_complete = 1'b0;
          pt_return   = 'z;
          wait_cnt    = 0;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    logic [7:0] exp_r;
    if (rst_n && resp_valid) begin
      n_resp++;
      last_resp_cyc = cyc;
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_resp: got fault=%0b hit=%0b ppn=%h, none expected",
                 resp_fault, resp_hit, resp_ppn);
      end else begin
        exp_r = sb.pop_front();
        if ({resp_fault, resp_hit, resp_ppn} !== exp_r) begin
          n_err++;
          $display("FAIL resp: got fault=%0b hit=%0b ppn=%h, want fault=%0b hit=%0b ppn=%h",
                   resp_fault, resp_hit, resp_ppn, exp_r[7], exp_r[6], exp_r[5:0]);
        end
      end
    end
  end

  task automatic wait_idle();
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      #1;
      if (req_ready) return;
    end
    n_vec++;
    n_err++;
    $display("FAIL wait_idle: req_ready got 0 for 200 cycles, want 1");
  endtask

  task automatic wait_resp(input int r0, input string name);
    for (int k = 0; k < Timeout + 20; k++) begin
      if (n_resp != r0) return;
      @(negedge clk);
      #1;
    end
    n_vec++;
    n_err++;
    $display("FAIL %s_timeout: responses got %0d, want %0d", name, n_resp - r0, 1);
  endtask

  task automatic do_req(input logic [5:0] vpn, input bit exp_hit, input bit exp_fault,
                        input bit flush_lk, input string name);
    int acc, r0;
    wait_idle();
    r0 = n_resp;
    sb.push_back({exp_fault, exp_hit, exp_fault ? 6'h00 : ppn_of(vpn)});
    req_vpn   = vpn;
    req_valid = 1'b1;
    @(posedge clk);
    #1 acc = cyc;
    req_valid = 1'b0;
    if (flush_lk) flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    #1;
    n_vec++;
    if (pt_rqst !== !exp_hit) begin
      n_err++;
      $display("FAIL %s_pt_rqst: got %0b, want %0b", name, pt_rqst, !exp_hit);
    end
    if (!exp_hit) begin
      n_vec++;
      if (pt_addr !== vpn) begin
        n_err++;
        $display("FAIL %s_pt_addr: got %h, want %h", name, pt_addr, vpn);
      end
    end
    wait_resp(r0, name);
    n_vec++;
    if (exp_hit && (last_resp_cyc - acc + 1) != 2) begin
      n_err++;
      $display("FAIL %s_hit_latency: got %0d, want 2", name, last_resp_cyc - acc + 1);
    end else if (exp_fault && (last_resp_cyc - acc + 1) != Timeout + 2) begin
      n_err++;
      $display("FAIL %s_fault_latency: got %0d, want %0d", name, last_resp_cyc - acc + 1,
               Timeout + 2);
    end else if (!exp_hit && !exp_fault && last_resp_cyc != pt_cmp_cyc + 2) begin
      n_err++;
      $display("FAIL %s_miss_latency: got %0d, want %0d", name, last_resp_cyc - pt_cmp_cyc, 2);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_vpn   = '0;
    flush     = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    n_vec += 7;
    if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %0b, want 1", req_ready); end
    if (resp_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %0b, want 0", resp_valid); end
    if (resp_ppn !== 6'h00) begin n_err++; $display("FAIL rst_ppn: got %h, want 00", resp_ppn); end
    if (resp_hit !== 1'b0) begin n_err++; $display("FAIL rst_hit: got %0b, want 0", resp_hit); end
    if (resp_fault !== 1'b0) begin n_err++; $display("FAIL rst_fault: got %0b, want 0", resp_fault); end
    if (pt_rqst !== 1'b0) begin n_err++; $display("FAIL rst_pt_rqst: got %0b, want 0", pt_rqst); end
    if (pt_addr !== 6'h00) begin n_err++; $display("FAIL rst_pt_addr: got %h, want 00", pt_addr); end
  endtask

  task automatic test_basic();
    do_req(6'h05, 1'b0, 1'b0, 1'b0, "basic_miss");
    do_req(6'h05, 1'b1, 1'b0, 1'b0, "basic_hit");
  endtask

  task automatic test_evict();
    do_req(6'h11, 1'b0, 1'b0, 1'b0, "fill1");
    do_req(6'h12, 1'b0, 1'b0, 1'b0, "fill2");
    do_req(6'h13, 1'b0, 1'b0, 1'b0, "fill3");
    do_req(6'h14, 1'b0, 1'b0, 1'b0, "fill_evict");
    do_req(6'h11, 1'b1, 1'b0, 1'b0, "evict_keep");
    do_req(6'h05, 1'b0, 1'b0, 1'b0, "evict_gone");
  endtask

  task automatic test_fault();
    pt_en = 1'b0;
    do_req(6'h3F, 1'b0, 1'b1, 1'b0, "fault");
    pt_en = 1'b1;
    do_req(6'h3F, 1'b0, 1'b0, 1'b0, "fault_nofill");
  endtask

  task automatic test_flush();
    int  r0;
    bit  seen;
    wait_idle();
    r0 = n_resp;
    sb.push_back({2'b00, ppn_of(6'h22)});
    req_vpn   = 6'h22;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (pt_rqst) seen = 1'b1;
      else if (seen) begin
        flush = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1 flush = 1'b0;
    wait_resp(r0, "flush_fill");
    do_req(6'h22, 1'b0, 1'b0, 1'b0, "flush_fill_gone");
    do_req(6'h22, 1'b1, 1'b0, 1'b0, "refill_hit");
    do_req(6'h22, 1'b0, 1'b0, 1'b1, "flush_lookup");
  endtask

  task automatic test_reset_mid_miss();
    int r0;
    pt_en = 1'b0;
    wait_idle();
    r0 = n_resp;
    req_vpn   = 6'h2B;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec += 2;
    if (pt_rqst !== 1'b0) begin n_err++; $display("FAIL midrst_pt_rqst: got %0b, want 0", pt_rqst); end
    if (req_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready: got %0b, want 1", req_ready); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pt_en = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_vec++;
    if (n_resp != r0) begin
      n_err++;
      $display("FAIL midrst_noresp: responses got %0d, want 0", n_resp - r0);
    end
    do_req(6'h05, 1'b0, 1'b0, 1'b0, "midrst_clean");
  endtask

  task automatic test_back_to_back();
    int r0, resp_at, acc2;
    wait_idle();
    r0      = n_resp;
    resp_at = -1;
    acc2    = -1;
    sb.push_back({2'b00, ppn_of(6'h30)});
    req_vpn   = 6'h30;
    req_valid = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      #1;
      if (n_resp == r0 + 1 && resp_at < 0) resp_at = last_resp_cyc;
      if (req_ready) begin
        sb.push_back({2'b01, ppn_of(6'h30)});
        @(posedge clk);
        #1 acc2 = cyc;
        req_valid = 1'b0;
        break;
      end
    end
    req_valid = 1'b0;
    n_vec += 2;
    if (n_resp != r0 + 1) begin
      n_err++;
      $display("FAIL b2b_one_resp: responses before 2nd accept got %0d, want 1", n_resp - r0);
    end
    // resp_at labels the cycle after the response edge; the response cycle ends one edge later.
    if (acc2 != resp_at + 3) begin
      n_err++;
      $display("FAIL b2b_accept: got resp+%0d, want resp+2", acc2 - resp_at - 1);
    end
    wait_resp(r0 + 1, "b2b_second");
    repeat (4) @(negedge clk);
    #1;
    n_vec++;
    if (n_resp != r0 + 2) begin
      n_err++;
      $display("FAIL b2b_count: responses got %0d, want 2", n_resp - r0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation got stuck, want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_evict();
    test_fault();
    test_flush();
    test_reset_mid_miss();
    test_back_to_back();
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: pending got %0d, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
